// File: rtl/axis_downsizer.sv
// axis_downsizer: AXI-Stream width downsizer.
//
// Each S_DATA_WIDTH input beat is split into up to RATIO = S_DATA_WIDTH / M_DATA_WIDTH output
// beats, one per output lane that has at least one tkeep bit set. Lanes with no kept bytes are
// skipped. tlast is raised on the last kept lane of a beat that carried tlast. An all-zero-keep
// beat with tlast set produces a single beat with tkeep = 0, so frame boundaries survive.
// tuser/tid/tdest are latched per input beat and repeated on each of its output beats.
//
// Optional feature (define AXIS_DOWNSIZER_STATS_EN): adds frame_count and byte_count outputs.
//
// Parameters:
//   S_DATA_WIDTH  input data width, multiple of M_DATA_WIDTH
//   M_DATA_WIDTH  output data width, multiple of 8
//   MSB_FIRST     0: lane 0 emitted first, 1: most-significant lane emitted first
//   USER_WIDTH, ID_WIDTH, DEST_WIDTH  sideband widths
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   s_axis_*                  wide input stream (tdata/tkeep/tvalid/tready/tlast/tuser/tid/tdest)
//   m_axis_*                  narrow output stream, same signal set
//   frame_count, byte_count   (stats build only) accepted tlast beats / accepted kept bytes

module axis_downsizer #(
    parameter int unsigned S_DATA_WIDTH = 16,
    parameter int unsigned M_DATA_WIDTH = 8,
    parameter int unsigned MSB_FIRST    = 0,
    parameter int unsigned USER_WIDTH   = 1,
    parameter int unsigned ID_WIDTH     = 8,
    parameter int unsigned DEST_WIDTH   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [S_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [S_DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic                      s_axis_tlast,
    input  logic [USER_WIDTH-1:0]     s_axis_tuser,
    input  logic [ID_WIDTH-1:0]       s_axis_tid,
    input  logic [DEST_WIDTH-1:0]     s_axis_tdest,
    output logic [M_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [M_DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    output logic [USER_WIDTH-1:0]     m_axis_tuser,
    output logic [ID_WIDTH-1:0]       m_axis_tid,
    output logic [DEST_WIDTH-1:0]     m_axis_tdest
`ifdef AXIS_DOWNSIZER_STATS_EN
    ,
    output logic [31:0]               frame_count,
    output logic [31:0]               byte_count
`endif
);

    localparam int unsigned RATIO = S_DATA_WIDTH / M_DATA_WIDTH;
    localparam int unsigned SKW   = S_DATA_WIDTH / 8;
    localparam int unsigned MKW   = M_DATA_WIDTH / 8;
    localparam int unsigned PW    = (RATIO > 1) ? $clog2(RATIO) : 1;

    typedef enum logic [0:0] {StEmpty, StEmit} state_e;

    // Emission position -> physical lane index.
    function automatic int phys_lane(input int p);
        return (MSB_FIRST != 0) ? (int'(RATIO) - 1 - p) : p;
    endfunction

    // Is any position >= start set in the position-ordered kept mask?
    function automatic logic has_from(input logic [RATIO-1:0] mask, input int start);
        logic r;
        r = 1'b0;
        for (int p = 0; p < int'(RATIO); p++) begin
            if (p >= start && mask[p]) r = 1'b1;
        end
        return r;
    endfunction

    // Lowest set position >= start (0 when none).
    function automatic logic [PW-1:0] first_from(input logic [RATIO-1:0] mask, input int start);
        logic [PW-1:0] r;
        r = '0;
        for (int p = int'(RATIO) - 1; p >= 0; p--) begin
            if (p >= start && mask[p]) r = PW'(p);
        end
        return r;
    endfunction

    state_e                  state;
    logic [S_DATA_WIDTH-1:0] data_q;
    logic [SKW-1:0]          keep_q;
    logic [RATIO-1:0]        pmask_q;   // kept lanes, indexed by emission position
    logic [PW-1:0]           pos_q;     // emission position currently on m_axis
    logic                    last_q;

    logic [RATIO-1:0]        in_pmask;
    logic                    in_any;
    logic [PW-1:0]           in_pos;
    logic                    in_more;
    logic [M_DATA_WIDTH-1:0] in_lane_data;
    logic [MKW-1:0]          in_lane_keep;
    logic                    cur_more;
    logic [PW-1:0]           nxt_pos;
    logic                    nxt_more;
    logic [M_DATA_WIDTH-1:0] nxt_lane_data;
    logic [MKW-1:0]          nxt_lane_keep;
    logic                    s_fire;
    logic                    m_fire;

    always_comb begin
        in_pmask = '0;
        for (int p = 0; p < int'(RATIO); p++) begin
            in_pmask[p] = |s_axis_tkeep[phys_lane(p) * MKW +: MKW];
        end
        in_any        = has_from(in_pmask, 0);
        in_pos        = first_from(in_pmask, 0);
        in_more       = has_from(in_pmask, int'(in_pos) + 1);
        in_lane_data  = s_axis_tdata[phys_lane(int'(in_pos)) * M_DATA_WIDTH +: M_DATA_WIDTH];
        in_lane_keep  = s_axis_tkeep[phys_lane(int'(in_pos)) * MKW +: MKW];

        cur_more      = has_from(pmask_q, int'(pos_q) + 1);
        nxt_pos       = first_from(pmask_q, int'(pos_q) + 1);
        nxt_more      = has_from(pmask_q, int'(nxt_pos) + 1);
        nxt_lane_data = data_q[phys_lane(int'(nxt_pos)) * M_DATA_WIDTH +: M_DATA_WIDTH];
        nxt_lane_keep = keep_q[phys_lane(int'(nxt_pos)) * MKW +: MKW];
    end

    assign m_axis_tvalid = (state == StEmit);
    // A new beat can load in the same cycle the final lane of the current one is taken.
    assign s_axis_tready = !rst && ((state == StEmpty) || (m_axis_tready && !cur_more));
    assign s_fire        = s_axis_tvalid && s_axis_tready;
    assign m_fire        = m_axis_tvalid && m_axis_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= StEmpty;
            data_q       <= '0;
            keep_q       <= '0;
            pmask_q      <= '0;
            pos_q        <= '0;
            last_q       <= 1'b0;
            m_axis_tdata <= '0;
            m_axis_tkeep <= '0;
            m_axis_tlast <= 1'b0;
            m_axis_tuser <= '0;
            m_axis_tid   <= '0;
            m_axis_tdest <= '0;
        end else if (m_fire && cur_more) begin
            pos_q        <= nxt_pos;
            m_axis_tdata <= nxt_lane_data;
            m_axis_tkeep <= nxt_lane_keep;
            m_axis_tlast <= last_q && !nxt_more;
        end else if (s_fire) begin
            // A null beat carries zero data so its single tlast beat shows tdata = 0.
            data_q       <= in_any ? s_axis_tdata : '0;
            keep_q       <= s_axis_tkeep;
            pmask_q      <= in_pmask;
            pos_q        <= in_pos;
            last_q       <= s_axis_tlast;
            m_axis_tdata <= in_any ? in_lane_data : '0;
            m_axis_tkeep <= in_lane_keep;
            m_axis_tlast <= s_axis_tlast && !in_more;
            m_axis_tuser <= s_axis_tuser;
            m_axis_tid   <= s_axis_tid;
            m_axis_tdest <= s_axis_tdest;
            // Null beat without tlast is swallowed.
            state        <= (in_any || s_axis_tlast) ? StEmit : StEmpty;
        end else if (m_fire) begin
            state <= StEmpty;
        end
    end

`ifdef AXIS_DOWNSIZER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_count <= '0;
            byte_count  <= '0;
        end else if (m_fire) begin
            if (m_axis_tlast) frame_count <= frame_count + 32'd1;
            byte_count <= byte_count + 32'($countones(m_axis_tkeep));
        end
    end
`else
    // Statistics counters are not built.
`endif

endmodule

// File: doc/axis_downsizer.md
Name: axis_downsizer

Overview:
- Parametrised AXI-Stream width downsizer: each S_DATA_WIDTH input beat is split into RATIO = S_DATA_WIDTH/M_DATA_WIDTH output beats.
- Honours tkeep at output-lane granularity; lanes with no kept bytes are skipped.
- Propagates tlast, tuser, tid and tdest.
- Sits between wide internal datapaths (e.g. 16/32-bit sample streams) and byte-wide transports such as the UART/USB FIFO paths.

Parameters:
- S_DATA_WIDTH, 16, input data width; multiple of M_DATA_WIDTH.
- M_DATA_WIDTH, 8, output data width; multiple of 8.
- MSB_FIRST, 0: 0 = lane 0 (bits M-1:0) emitted first; 1 = most-significant lane emitted first.
- USER_WIDTH, 1, tuser width.
- ID_WIDTH, 8, tid width.
- DEST_WIDTH, 8, tdest width.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- s_axis_tdata  input  S_DATA_WIDTH  input data
- s_axis_tkeep  input  S_DATA_WIDTH/8  byte-valid mask
- s_axis_tvalid  input  1  input valid
- s_axis_tready  output  1  input ready
- s_axis_tlast  input  1  end of frame
- s_axis_tuser  input  USER_WIDTH  sideband
- s_axis_tid  input  ID_WIDTH  stream id
- s_axis_tdest  input  DEST_WIDTH  routing
- m_axis_tdata  output  M_DATA_WIDTH  output lane data
- m_axis_tkeep  output  M_DATA_WIDTH/8  output lane keep
- m_axis_tvalid  output  1  output valid
- m_axis_tready  input  1  output ready
- m_axis_tlast  output  1  end of frame
- m_axis_tuser  output  USER_WIDTH  copied from the source beat
- m_axis_tid  output  ID_WIDTH  copied from the source beat
- m_axis_tdest  output  DEST_WIDTH  copied from the source beat

Behaviour:
- Interface (already decided): single clock clk; rst is synchronous, active-high.
- Reset values:
  - m_axis_tvalid = 0, s_axis_tready = 0 during rst, 1 the first cycle after it.
  - m_axis_tdata/tkeep/tlast/tuser/tid/tdest = 0.
  - Holding register cleared; lane index cleared.
- Lane structure: lane k = tdata bits [k*M +: M], with keep bits [k*M/8 +: M/8]. A lane is "kept" if any of its keep bits is 1.
- States:
  - EMPTY: s_axis_tready = 1. On s_tvalid & s_tready, the beat is registered into the holding register and the state moves to EMIT. The first output beat becomes valid the next cycle, giving 1-cycle latency.
  - EMIT: m_axis_tvalid = 1 with the current kept lane. On m_tready, advance to the next kept lane in emission order (MSB_FIRST sets the order).
    - m_axis_tlast = source tlast AND current lane is the last kept lane.
- Full throughput: in EMIT, s_axis_tready = m_axis_tready AND the current lane is the last kept lane. A new beat may load in the same cycle the final lane is accepted, with no bubble.
  - Sustained rate = one output beat per cycle.
  - A full-keep input beat is accepted every RATIO cycles.
- Null beat: an input beat with tkeep all zero.
  - tlast = 0: consumed, nothing emitted.
  - tlast = 1: emits exactly one beat with m_tkeep = 0, m_tdata = 0, m_tlast = 1. Frame boundaries are never lost.
- Partial lanes: m_axis_tkeep is the source keep slice, unmodified; bytes inside a lane are not repacked.
- Backpressure: while m_tvalid = 1 and m_tready = 0, all m_axis outputs hold stable (AXIS rule).
- Sideband: tuser/tid/tdest are latched per input beat and are constant across all of its output beats.
- Reset mid-operation: the partial beat is discarded and outputs return to reset values the next cycle. No beat already accepted on s_axis is emitted after reset.
- Degenerate RATIO = 1: a registered pass-through with the same handshake rules.

Optional Feature:
- Macro AXIS_DOWNSIZER_STATS_EN. When defined, two extra outputs are added:
  - frame_count (32): increments on each m_axis beat accepted with tlast = 1.
  - byte_count (32): adds the popcount of m_axis_tkeep on each accepted beat.
  - Both wrap modulo 2^32, clear on rst, and update the cycle after the handshake.
- When undefined, neither port nor logic exists.

Test Plan:
1. 16→8, MSB_FIRST=0; drive 0x6971, keep=2'b11, tlast=1; m_tready=1 → out 0x71 (tlast=0) then 0x69 (tlast=1) on consecutive cycles. First output is valid 1 cycle after input acceptance.
2. Same beat with MSB_FIRST=1 and m_tready held 0 for 5 cycles → out 0x69, stable for 5 cycles with s_tready=0. Then 0x69, then 0x71 with tlast=1.
3. 32→8; stream 0x44332211, 0x88776655, each keep=4'hF, m_tready=1 → 8 output beats 11..88 with no idle cycle between them. s_tready pulses high on cycles 4 and 8 only; tlast=1 only on 0x88.
4. 32→8; keep=4'b0101, data 0xDDCCBBAA, tlast=1 → two beats: AA (tlast=0), then CC (tlast=1).
5. Null beat keep=0, tlast=1 → one beat with tkeep=0, tlast=1. Same beat with tlast=0 → no output, s_tready returns to 1 next cycle.
6. Assert rst after 1 of 4 lanes is emitted → m_tvalid=0 the next cycle; the remaining lanes are never output. With AXIS_DOWNSIZER_STATS_EN defined, frame_count and byte_count both read 0 after rst.
